// File: rtl/mul_types_pkg.sv
// Shared types for the RV32M multiply path.
//   riscv_mul_op_e : opcode presented to the multiplier by the ALU
//   alu_mul_t      : request bundle (operands + opcode) as carried on stage_if
//   mul_state_e    : sequencer states of booth_multiplier
//   MUL_ITERS      : number of radix-4 Booth steps for a 34-bit multiplier
package mul_types_pkg;

    typedef enum logic [2:0] {
        MUL_NONE = 3'd0,
        MUL      = 3'd1,
        MULH     = 3'd2,
        MULHSU   = 3'd3,
        MULHU    = 3'd4
    } riscv_mul_op_e;

    typedef struct packed {
        logic [31:0]   dataA;
        logic [31:0]   dataB;
        riscv_mul_op_e opcode;
    } alu_mul_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // 34-bit extended multiplier / 2 bits per step
    localparam int MUL_ITERS = 17;

endpackage

// File: rtl/add_and_sub.sv
// Combinational adder/subtractor shared with the ALU.
//   A, B     : operands
//   Cin      : 0 = A + B, 1 = A - B (B inverted, carry-in 1)
//   Result   : A + (Cin ? ~B : B) + Cin
//   Carry    : carry out of the MSB
//   Overflow : two's-complement overflow
//   zero     : Result == 0
module add_and_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             zero
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    assign b_eff    = Cin ? ~B : B;
    assign sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
    assign Result   = sum[WIDTH-1:0];
    assign Carry    = sum[WIDTH];
    // Overflow when both addends share a sign that the result does not.
    assign Overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) && (Result[WIDTH-1] != A[WIDTH-1]);
    assign zero     = (Result == '0);

endmodule

// File: rtl/booth_multiplier.sv
// Sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-4 Booth,
// 17 steps, fixed latency, valid/ready on both sides.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake (mul_in)
//   in_dataA/in_dataB : multiplicand rs1 / multiplier rs2
//   in_opcode         : riscv_mul_op_e
//   out_valid/out_ready/out_result : response handshake (mul_out)
module booth_multiplier
    import mul_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dataA,
    input  logic [WIDTH-1:0] in_dataB,
    input  logic [2:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int EXT_W = WIDTH + 2;   // operands after sign/zero extension
    localparam int ACC_W = WIDTH + 4;   // holds partial sums of up to +-2M with headroom
    localparam int CNT_W = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

    mul_state_e       state_q, state_d;
    logic [EXT_W-1:0] m_q, m_d;       // extended multiplicand
    logic [EXT_W-1:0] b_q, b_d;       // multiplier, refilled from the top with product bits
    logic             prev_q, prev_d; // b[2i-1]
    logic [ACC_W-1:0] acc_q, acc_d;   // upper (signed) accumulator
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [2:0]         booth_bits;
    logic [ACC_W-1:0]   m_ext, m2_ext, addend, sum;
    logic               subtract;
    logic [ACC_W-1:0]   acc_shift;
    logic [EXT_W-1:0]   b_shift;
    logic [2*WIDTH-1:0] prod_next;
    logic               a_sgn, b_sgn;
    logic               carry, ovf, sum_zero;
    logic               unused_flags;

    assign booth_bits = {b_q[1], b_q[0], prev_q};
    assign m_ext      = {{(ACC_W-EXT_W){m_q[EXT_W-1]}}, m_q};
    assign m2_ext     = {m_ext[ACC_W-2:0], 1'b0};

    // Booth digit -> {0, +-M, +-2M}; negative digits use the subtract path.
    always_comb begin
        addend   = '0;
        subtract = 1'b0;
        case (booth_bits)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m2_ext;
            3'b100: begin
                addend   = m2_ext;
                subtract = 1'b1;
            end
            3'b101, 3'b110: begin
                addend   = m_ext;
                subtract = 1'b1;
            end
            default: ;
        endcase
    end

    add_and_sub #(.WIDTH(ACC_W)) u_add_and_sub (
        .A        (acc_q),
        .B        (addend),
        .Cin      (subtract),
        .Result   (sum),
        .Carry    (carry),
        .Overflow (ovf),
        .zero     (sum_zero)
    );

    // Flags are for ALU use; the accumulator is sized so they never matter here.
    assign unused_flags = ^{carry, ovf, sum_zero};

    // {acc, b} behaves as one register shifted arithmetically right by 2.
    assign acc_shift = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    assign b_shift   = {sum[1:0], b_q[EXT_W-1:2]};
    assign prod_next = {acc_shift[2*WIDTH-EXT_W-1:0], b_shift};

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (in_opcode)
            MUL, MULH: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            MULHSU:  a_sgn = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        b_d      = b_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d     = {{2{in_dataA[WIDTH-1] & a_sgn}}, in_dataA};
                    b_d     = {{2{in_dataB[WIDTH-1] & b_sgn}}, in_dataB};
                    prev_d  = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    op_d    = in_opcode;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d  = acc_shift;
                b_d    = b_shift;
                prev_d = b_q[1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    case (op_q)
                        MUL:                 result_d = prod_next[WIDTH-1:0];
                        MULH, MULHSU, MULHU: result_d = prod_next[2*WIDTH-1:WIDTH];
                        default:             result_d = '0;
                    endcase
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            b_q      <= '0;
            prev_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            b_q      <= b_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;
    import mul_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_dataA, in_dataB, out_result;
    logic [2:0]  in_opcode;

    booth_multiplier #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dataA   (in_dataA),
        .in_dataB   (in_dataB),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          out_count = 0;
    int          fire_e0 = 0;
    bit          lat_pending = 1'b0;
    logic        ov_prev = 1'b0;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [65:0] ea, eb, p;
        logic        as_, bs_;
        as_ = (op == MUL) || (op == MULH) || (op == MULHSU);
        bs_ = (op == MUL) || (op == MULH);
        ea  = {{34{as_ & a[31]}}, a};
        eb  = {{34{bs_ & b[31]}}, b};
        p   = ea * eb;
        case (op)
            MUL:                 return p[31:0];
            MULH, MULHSU, MULHU: return p[63:32];
            default:             return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Scoreboard: observes both handshakes once per cycle on the falling edge.
    task automatic mon();
        logic [31:0] e;
        if (!rst) begin
            exp_q.delete();
            lat_pending = 1'b0;
        end else begin
            if (out_valid && !ov_prev && lat_pending) begin
                chk("latency", 32'(cyc - fire_e0), 32'd17);
                lat_pending = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output got=%h exp=none", out_result);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d result=%h exp=%h", out_count, out_result, e);
                    if (out_result !== e) begin
                        errors++;
                        $display("FAIL sb_result got=%h exp=%h", out_result, e);
                    end
                end
                out_count++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_result(in_opcode, in_dataA, in_dataB));
                fire_e0     = cyc + 1;
                lat_pending = 1'b1;
            end
        end
        ov_prev = out_valid;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Both waits end right after a tick; the caller follows with adv().
    task automatic wait_fire();
        int n = 0;
        tick();
        while (!in_ready && n < 50) begin
            adv();
            tick();
            n++;
        end
        chk("fire_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        tick();
        while (!out_valid && n < 100) begin
            adv();
            tick();
            n++;
        end
        chk("done_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
        in_valid  = 1'b1;
        in_opcode = op;
        in_dataA  = a;
        in_dataB  = b;
        out_ready = 1'b1;
        wait_fire();
        adv();
        in_valid  = 1'b0;
        in_dataA  = $urandom();
        in_dataB  = $urandom();
        in_opcode = 3'($urandom_range(4));
        wait_done();
        res = out_result;
        adv();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] res, held;
        int          issued, gap, base;
        int          n_ops;
        bit          fired;

        vecs[0] = '{MUL,      32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1] = '{MUL,      32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
        vecs[2] = '{MULH,     32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3] = '{MULHU,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4] = '{MULHSU,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{MULHSU,   32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
        vecs[6] = '{MUL_NONE, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000};
        vecs[7] = '{MULH,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{MULH,     32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};
        vecs[9] = '{MULHU,    32'h8000_0000, 32'h0000_0002, 32'h0000_0001};

        in_valid  = 1'b0;
        in_dataA  = '0;
        in_dataB  = '0;
        in_opcode = '0;
        out_ready = 1'b0;
        rst       = 1'b0;

        // Reset state
        tick();
        chk("rst_in_ready",   {31'b0, in_ready},  32'd1);
        chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result,         32'd0);
        adv();
        rst = 1'b1;
        tick();
        adv();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res);
            chk($sformatf("vec%0d", i), res, vecs[i].exp);
        end

        // Backpressure in DONE for 5 cycles, then back-to-back accept
        in_valid  = 1'b1;
        in_opcode = MULHU;
        in_dataA  = 32'hFFFF_FFFF;
        in_dataB  = 32'h0000_0003;
        out_ready = 1'b0;
        wait_fire();
        adv();
        in_valid = 1'b0;
        wait_done();
        held = out_result;
        chk("bp_result", held, 32'h0000_0002);
        for (int k = 0; k < 5; k++) begin
            adv();
            tick();
            chk($sformatf("bp_valid%0d", k),  {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp_hold%0d", k),   out_result,         held);
            chk($sformatf("bp_ready%0d", k),  {31'b0, in_ready},  32'd0);
        end
        adv();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_opcode = MUL;
        in_dataA  = 32'd9;
        in_dataB  = 32'd9;
        tick();
        adv();
        tick();
        chk("bp_next_ready", {31'b0, in_ready}, 32'd1);
        adv();
        in_valid = 1'b0;
        wait_done();
        chk("bp_next_result", out_result, 32'h0000_0051);
        adv();
        out_ready = 1'b0;

        // Reset during CALC step 8
        in_valid  = 1'b1;
        in_opcode = MUL;
        in_dataA  = 32'd123;
        in_dataB  = 32'd456;
        out_ready = 1'b1;
        wait_fire();
        adv();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            adv();
        end
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",   {31'b0, in_ready},  32'd1);
        chk("mid_rst_out_result", out_result,         32'd0);
        adv();
        rst = 1'b1;
        tick();
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_in_ready",  {31'b0, in_ready},  32'd1);
        adv();
        do_op(MUL, 32'd3, 32'd4, res);
        chk("post_rst_mul", res, 32'h0000_000C);

        // Random sweep with random backpressure and in_valid held while busy
        n_ops     = 2000;
        issued    = 0;
        gap       = 0;
        base      = out_count;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 60000 && (out_count - base) < n_ops; c++) begin
            if (!in_valid && issued < n_ops && gap == 0) begin
                in_valid  = 1'b1;
                in_dataA  = rand_operand();
                in_dataB  = rand_operand();
                in_opcode = 3'($urandom_range(4));
            end
            out_ready = ($urandom_range(3) != 0);
            tick();
            fired = in_valid && in_ready;
            adv();
            if (fired) begin
                issued++;
                in_valid = 1'b0;
                gap      = $urandom_range(2);
            end else if (!in_valid && gap > 0) begin
                gap--;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("sweep_count",       32'(out_count - base), 32'(n_ops));
        chk("sweep_queue_empty", 32'(exp_q.size()),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
